neorv32_wb_arbiter: RTL and testbench



---
 rtl/neorv32_wb_arbiter_pkg.sv | 43 ++++
 rtl/wb_req_capture.sv | 52 +++++
 rtl/neorv32_wb_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_neorv32_wb_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neorv32_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// neorv32_wb_arbiter_pkg
// Shared types for the instruction/data bus to Wishbone arbiter:
//   state_t  - transaction FSM states (IDLE, BUS, RESP)
//   grant_t  - which CPU port owns the bus
//   req_t    - one latched bus request (address, write data, byte select, we)
//   arbitrate() - winner selection between two candidate requests
// ----------------------------------------------------------------------------
package neorv32_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
    } req_t;

    // With both ports requesting: dbus wins outright when dbus_first is set,
    // otherwise the port that did not get the previous grant wins.
    function automatic grant_t arbitrate(input logic   i_valid,
                                         input logic   d_valid,
                                         input grant_t last,
                                         input logic   dbus_first);
        if (i_valid && d_valid) begin
            if (dbus_first || (last == GRANT_I)) return GRANT_D;
            return GRANT_I;
        end
        if (d_valid) return GRANT_D;
        return GRANT_I;
    endfunction

endpackage

// File: rtl/wb_req_capture.sv
// ----------------------------------------------------------------------------
// wb_req_capture
// Holds one CPU port's outstanding request until the arbiter grants it.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_stb      - single-cycle request strobe from the CPU port
//   i_req      - request fields, valid with i_stb
//   i_busy     - this port's previous request is currently on the bus
//   i_grant    - arbiter takes the request this edge (clears pending)
//   o_valid    - a request is available (latched, or arriving this cycle)
//   o_req      - fields of that request
// ----------------------------------------------------------------------------
module wb_req_capture
    import neorv32_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_stb,
    input  req_t i_req,
    input  logic i_busy,
    input  logic i_grant,
    output logic o_valid,
    output req_t o_req
);

    logic r_pending;
    req_t r_req;
    logic w_take;

    // A strobe is accepted only when nothing of this port is waiting or on
    // the bus; a second strobe in that window is a CPU protocol violation
    // and is dropped.
    assign w_take = i_stb && !r_pending && !i_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_req     <= '0;
        end else if (i_grant) begin
            // A request granted in the same cycle it arrives never becomes
            // pending; the arbiter loads it straight from o_req.
            r_pending <= 1'b0;
        end else if (w_take) begin
            r_pending <= 1'b1;
            r_req     <= i_req;
        end
    end

    assign o_valid = r_pending || w_take;
    assign o_req   = r_pending ? r_req : i_req;

endmodule

// File: rtl/neorv32_wb_arbiter.sv
// ----------------------------------------------------------------------------
// neorv32_wb_arbiter
// Shares one Wishbone classic master port between the neorv32 instruction
// bus and data bus. One transaction at a time; a watchdog aborts a
// transaction that never sees core_ack_i.
//
// Handshake: a CPU port raises *_stb_i for exactly one cycle with its fields
// valid; it must not strobe again until it has seen its one-cycle
// *_rsp_ack_o or *_rsp_err_o. On the Wishbone side core_cyc_o/core_stb_o and
// all core_* fields stay stable until the edge where core_ack_i is sampled
// high (or the watchdog expires); cyc/stb then drop for at least one cycle.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ibus_stb_i, ibus_addr_i        instruction fetch request
//   ibus_rsp_data/ack/err_o        fetch response (one-cycle pulses)
//   dbus_stb_i, dbus_rw_i,
//   dbus_addr_i, dbus_data_i,
//   dbus_ben_i                     data request
//   dbus_rsp_data/ack/err_o        data response (one-cycle pulses)
//   core_cyc/stb/we/sel/addr/data_o Wishbone master outputs
//   core_data_i, core_ack_i        Wishbone read data and acknowledge
//   dbg_state_o                    current FSM state for observation
// ----------------------------------------------------------------------------
module neorv32_wb_arbiter
    import neorv32_wb_arbiter_pkg::*;
#(
    parameter int DBUS_PRIORITY  = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_stb_i,
    input  logic [31:0] ibus_addr_i,
    output logic [31:0] ibus_rsp_data_o,
    output logic        ibus_rsp_ack_o,
    output logic        ibus_rsp_err_o,
    input  logic        dbus_stb_i,
    input  logic        dbus_rw_i,
    input  logic [31:0] dbus_addr_i,
    input  logic [31:0] dbus_data_i,
    input  logic [3:0]  dbus_ben_i,
    output logic [31:0] dbus_rsp_data_o,
    output logic        dbus_rsp_ack_o,
    output logic        dbus_rsp_err_o,
    output logic        core_cyc_o,
    output logic        core_stb_o,
    output logic        core_we_o,
    output logic [3:0]  core_sel_o,
    output logic [31:0] core_addr_o,
    output logic [31:0] core_data_o,
    input  logic [31:0] core_data_i,
    input  logic        core_ack_i,
    output state_t      dbg_state_o
);

    localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                 TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic                 DBUS_FIRST = (DBUS_PRIORITY != 0);

    // FSM and bus-side registers
    state_t               r_state;
    grant_t               r_grant;
    grant_t               r_last;
    logic [TMO_WIDTH-1:0] r_tmo;
    logic                 r_cyc;
    logic                 r_we;
    logic [3:0]           r_sel;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;

    // Response registers
    logic                 r_i_ack;
    logic                 r_i_err;
    logic [31:0]          r_i_data;
    logic                 r_d_ack;
    logic                 r_d_err;
    logic [31:0]          r_d_data;

    req_t                 w_i_in;
    req_t                 w_d_in;
    req_t                 w_i_req;
    req_t                 w_d_req;
    req_t                 w_req;
    logic                 w_i_valid;
    logic                 w_d_valid;
    logic                 w_any;
    logic                 w_can_grant;
    logic                 w_i_busy;
    logic                 w_d_busy;
    logic                 w_i_grant;
    logic                 w_d_grant;
    grant_t               w_sel;
    logic [TMO_WIDTH-1:0] w_tmo_next;
    logic                 w_timeout;

    // Fetches are always full-word reads.
    always_comb begin
        w_i_in = '{addr: ibus_addr_i, data: 32'h0, sel: 4'hF, we: 1'b0};
        w_d_in = '{addr: dbus_addr_i, data: dbus_data_i, sel: dbus_ben_i, we: dbus_rw_i};
    end

    assign w_i_busy = (r_state == BUS) && (r_grant == GRANT_I);
    assign w_d_busy = (r_state == BUS) && (r_grant == GRANT_D);

    wb_req_capture u_cap_i (
        .clk     (clk),
        .rst     (rst),
        .i_stb   (ibus_stb_i),
        .i_req   (w_i_in),
        .i_busy  (w_i_busy),
        .i_grant (w_i_grant),
        .o_valid (w_i_valid),
        .o_req   (w_i_req)
    );

    wb_req_capture u_cap_d (
        .clk     (clk),
        .rst     (rst),
        .i_stb   (dbus_stb_i),
        .i_req   (w_d_in),
        .i_busy  (w_d_busy),
        .i_grant (w_d_grant),
        .o_valid (w_d_valid),
        .o_req   (w_d_req)
    );

    // RESP is the single turnaround cycle: a waiting request is granted at
    // its closing edge, so back-to-back transactions leave cyc low for
    // exactly one cycle.
    assign w_can_grant = (r_state == IDLE) || (r_state == RESP);
    assign w_any       = w_i_valid || w_d_valid;
    assign w_sel       = arbitrate(w_i_valid, w_d_valid, r_last, DBUS_FIRST);
    assign w_req       = (w_sel == GRANT_D) ? w_d_req : w_i_req;
    assign w_i_grant   = w_can_grant && w_any && (w_sel == GRANT_I);
    assign w_d_grant   = w_can_grant && w_any && (w_sel == GRANT_D);

    assign w_tmo_next  = r_tmo + 1'b1;
    assign w_timeout   = TMO_EN && (w_tmo_next == TMO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= GRANT_I;
            r_last   <= GRANT_I;
            r_tmo    <= '0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_i_ack  <= 1'b0;
            r_i_err  <= 1'b0;
            r_i_data <= '0;
            r_d_ack  <= 1'b0;
            r_d_err  <= 1'b0;
            r_d_data <= '0;
        end else begin
            // Responses are single-cycle pulses; data is only non-zero with ack.
            r_i_ack  <= 1'b0;
            r_i_err  <= 1'b0;
            r_i_data <= '0;
            r_d_ack  <= 1'b0;
            r_d_err  <= 1'b0;
            r_d_data <= '0;

            case (r_state)
                IDLE, RESP: begin
                    r_tmo <= '0;
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_last  <= w_sel;
                        r_cyc   <= 1'b1;
                        r_we    <= w_req.we;
                        r_sel   <= w_req.sel;
                        r_addr  <= w_req.addr;
                        r_wdata <= w_req.data;
                        r_state <= BUS;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                BUS: begin
                    // Ack takes precedence over a watchdog expiry on the same edge.
                    if (core_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_state <= RESP;
                        if (r_grant == GRANT_I) begin
                            r_i_ack  <= 1'b1;
                            r_i_data <= r_we ? 32'h0 : core_data_i;
                        end else begin
                            r_d_ack  <= 1'b1;
                            r_d_data <= r_we ? 32'h0 : core_data_i;
                        end
                    end else if (w_timeout) begin
                        r_cyc   <= 1'b0;
                        r_state <= RESP;
                        if (r_grant == GRANT_I) r_i_err <= 1'b1;
                        else                    r_d_err <= 1'b1;
                    end else begin
                        r_tmo <= w_tmo_next;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_cyc_o      = r_cyc;
    assign core_stb_o      = r_cyc;
    assign core_we_o       = r_we;
    assign core_sel_o      = r_sel;
    assign core_addr_o     = r_addr;
    assign core_data_o     = r_wdata;
    assign ibus_rsp_ack_o  = r_i_ack;
    assign ibus_rsp_err_o  = r_i_err;
    assign ibus_rsp_data_o = r_i_data;
    assign dbus_rsp_ack_o  = r_d_ack;
    assign dbus_rsp_err_o  = r_d_err;
    assign dbus_rsp_data_o = r_d_data;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_neorv32_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_neorv32_wb_arbiter
// Two arbiters (round-robin and dbus-priority) driven in lockstep by the same
// CPU-side stimulus and the same memory responses. A transaction-level model
// predicts, per instance, the order in which requests reach the bus; the
// expected bus words sit in exp_q and are compared when cyc rises, while
// the bus is held, and against the one-cycle response.
// Expected word layout: {port(1=dbus), we, sel[3:0], addr[31:0], data[31:0]}.
// ----------------------------------------------------------------------------
module tb_neorv32_wb_arbiter;
    import neorv32_wb_arbiter_pkg::*;

    localparam int TMO      = 8;
    localparam int W        = 72;
    localparam int N_RANDOM = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        ibus_stb;
    logic [31:0] ibus_addr;
    logic        dbus_stb;
    logic        dbus_rw;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_ben;
    logic [31:0] core_rdata;
    logic        core_ack;

    // ---------------- per-instance outputs (0 = round-robin, 1 = dbus priority) ----
    logic [1:0]  i_ack, i_err, d_ack, d_err, cyc, stb, we;
    logic [31:0] i_rdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic [3:0]  sel     [2];
    state_t      dbg     [2];

    neorv32_wb_arbiter #(.DBUS_PRIORITY(0), .TIMEOUT_CYCLES(TMO), .TMO_WIDTH(4)) u_dut_rr (
        .clk(clk), .rst(rst),
        .ibus_stb_i(ibus_stb), .ibus_addr_i(ibus_addr),
        .ibus_rsp_data_o(i_rdata[0]), .ibus_rsp_ack_o(i_ack[0]), .ibus_rsp_err_o(i_err[0]),
        .dbus_stb_i(dbus_stb), .dbus_rw_i(dbus_rw), .dbus_addr_i(dbus_addr),
        .dbus_data_i(dbus_wdata), .dbus_ben_i(dbus_ben),
        .dbus_rsp_data_o(d_rdata[0]), .dbus_rsp_ack_o(d_ack[0]), .dbus_rsp_err_o(d_err[0]),
        .core_cyc_o(cyc[0]), .core_stb_o(stb[0]), .core_we_o(we[0]), .core_sel_o(sel[0]),
        .core_addr_o(addr[0]), .core_data_o(wdata[0]),
        .core_data_i(core_rdata), .core_ack_i(core_ack),
        .dbg_state_o(dbg[0])
    );

    neorv32_wb_arbiter #(.DBUS_PRIORITY(1), .TIMEOUT_CYCLES(TMO), .TMO_WIDTH(4)) u_dut_dp (
        .clk(clk), .rst(rst),
        .ibus_stb_i(ibus_stb), .ibus_addr_i(ibus_addr),
        .ibus_rsp_data_o(i_rdata[1]), .ibus_rsp_ack_o(i_ack[1]), .ibus_rsp_err_o(i_err[1]),
        .dbus_stb_i(dbus_stb), .dbus_rw_i(dbus_rw), .dbus_addr_i(dbus_addr),
        .dbus_data_i(dbus_wdata), .dbus_ben_i(dbus_ben),
        .dbus_rsp_data_o(d_rdata[1]), .dbus_rsp_ack_o(d_ack[1]), .dbus_rsp_err_o(d_err[1]),
        .core_cyc_o(cyc[1]), .core_stb_o(stb[1]), .core_we_o(we[1]), .core_sel_o(sel[1]),
        .core_addr_o(addr[1]), .core_data_o(wdata[1]),
        .core_data_i(core_rdata), .core_ack_i(core_ack),
        .dbg_state_o(dbg[1])
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q [$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // current round: kind 1=ibus, 2=dbus, 3=both together,
    // 4=ibus then dbus during its bus phase, 5=dbus then ibus likewise
    int           kind;
    logic [31:0]  s_ia, s_da, s_dd;
    logic         s_rw;
    logic [3:0]   s_ben;
    int           lat [2];       // per slot: BUS cycles before memory acks
    bit           na  [2];       // per slot: memory never acks
    logic [31:0]  rd  [2];       // per slot: memory read data
    bit           lg  [2];       // per instance: last granted port (1 = dbus)
    bit           i_out [2];
    bit           d_out [2];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] bus_vec(input int j);
        return W'({cyc[j], stb[j], we[j], sel[j], addr[j], wdata[j]});
    endfunction

    function automatic logic [W-1:0] rsp_vec(input int j);
        return W'({i_ack[j], i_err[j], i_rdata[j], d_ack[j], d_err[j], d_rdata[j]});
    endfunction

    function automatic logic [W-1:0] ibus_word();
        return W'({1'b0, 1'b0, 4'hF, s_ia, 32'h0});
    endfunction

    function automatic logic [W-1:0] dbus_word();
        return W'({1'b1, s_rw, s_ben, s_da, s_dd});
    endfunction

    // Response seen in the cycle after ack/timeout: reads return the memory
    // word, writes and timeouts return zero data; the other port stays silent.
    function automatic logic [W-1:0] exp_rsp(input logic [W-1:0] w, input bit tmo,
                                             input logic [31:0] rdv);
        logic [31:0] dv;
        dv = (tmo || w[68]) ? 32'h0 : rdv;
        if (!w[69]) return W'({~tmo, tmo, dv, 1'b0, 1'b0, 32'h0});
        return W'({1'b0, 1'b0, 32'h0, ~tmo, tmo, dv});
    endfunction

    // CPU-side protocol: no second strobe on a port before its response.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                i_out[j] <= 1'b0;
                d_out[j] <= 1'b0;
            end else begin
                assert (!(ibus_stb && i_out[j] && !(i_ack[j] || i_err[j])))
                    else $error("protocol violation: ibus strobe while outstanding");
                assert (!(dbus_stb && d_out[j] && !(d_ack[j] || d_err[j])))
                    else $error("protocol violation: dbus strobe while outstanding");
                if (ibus_stb) i_out[j] <= 1'b1;
                else if (i_ack[j] || i_err[j]) i_out[j] <= 1'b0;
                if (dbus_stb) d_out[j] <= 1'b1;
                else if (d_ack[j] || d_err[j]) d_out[j] <= 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic plan(input int ns);
        bit [1:0] ord [2];    // ord[j][k] = port served in slot k (1 = dbus)
        for (int j = 0; j < 2; j++) begin
            case (kind)
                1: ord[j] = 2'b00;
                2: ord[j] = 2'b01;
                3: begin
                    ord[j][0] = (j == 1) ? 1'b1 : ~lg[j];
                    ord[j][1] = ~ord[j][0];
                end
                4: ord[j] = 2'b10;
                default: ord[j] = 2'b01;
            endcase
            lg[j] = ord[j][ns-1];
        end
        for (int k = 0; k < ns; k++)
            for (int j = 0; j < 2; j++)
                exp_q.push_back(ord[j][k] ? dbus_word() : ibus_word());
    endtask

    // ---------------- driver tasks ----------------
    task automatic randomize_round();
        s_ia  = $urandom;
        s_da  = $urandom;
        s_dd  = $urandom;
        s_rw  = 1'($urandom_range(0, 1));
        s_ben = 4'($urandom_range(0, 15));
        for (int k = 0; k < 2; k++) begin
            lat[k] = $urandom_range(0, 3);
            na[k]  = ($urandom_range(0, 7) == 0);
            rd[k]  = $urandom;
        end
    endtask

    task automatic drive_ibus();
        ibus_stb  = 1'b1;
        ibus_addr = s_ia;
    endtask

    task automatic drive_dbus();
        dbus_stb   = 1'b1;
        dbus_rw    = s_rw;
        dbus_addr  = s_da;
        dbus_wdata = s_dd;
        dbus_ben   = s_ben;
    endtask

    // Entered and left at a negedge with both instances idle.
    task automatic run_round();
        logic [W-1:0] w [2];
        int ns;
        bit tmo;
        ns = (kind == 1 || kind == 2) ? 1 : 2;
        plan(ns);
        if (kind == 1 || kind == 3 || kind == 4) drive_ibus();
        if (kind == 2 || kind == 3 || kind == 5) drive_dbus();
        @(posedge clk); @(negedge clk);
        ibus_stb   = 1'b0;
        dbus_stb   = 1'b0;
        ibus_addr  = $urandom;
        dbus_addr  = $urandom;
        dbus_wdata = $urandom;
        dbus_ben   = 4'($urandom_range(0, 15));
        dbus_rw    = 1'($urandom_range(0, 1));
        for (int k = 0; k < ns; k++) begin
            for (int j = 0; j < 2; j++) begin
                w[j] = exp_q.pop_front();
                check($sformatf("bus_req[%0d] k%0d", j, k), bus_vec(j), W'({2'b11, w[j][68:0]}));
                check($sformatf("rsp_quiet[%0d] k%0d", j, k), rsp_vec(j), '0);
            end
            if (k == 0 && kind == 4) drive_dbus();
            if (k == 0 && kind == 5) drive_ibus();
            tmo = 1'b0;
            core_rdata = rd[k];
            for (int c = 0; c < TMO; c++) begin
                core_ack = !na[k] && (c == lat[k]);
                @(posedge clk); @(negedge clk);
                ibus_stb = 1'b0;
                dbus_stb = 1'b0;
                if (core_ack) begin
                    core_ack = 1'b0;
                    break;
                end
                if (c == TMO - 1) begin
                    tmo = 1'b1;
                    break;
                end
                for (int j = 0; j < 2; j++) begin
                    check($sformatf("bus_hold[%0d] c%0d", j, c), bus_vec(j), W'({2'b11, w[j][68:0]}));
                    check($sformatf("bus_rsp_quiet[%0d] c%0d", j, c), rsp_vec(j), '0);
                end
            end
            for (int j = 0; j < 2; j++) begin
                check($sformatf("cyc_drop[%0d] k%0d", j, k), W'({cyc[j], stb[j]}), '0);
                check($sformatf("rsp[%0d] k%0d", j, k), rsp_vec(j), exp_rsp(w[j], tmo, rd[k]));
            end
            core_rdata = $urandom;
            @(posedge clk); @(negedge clk);
        end
        for (int j = 0; j < 2; j++) begin
            check($sformatf("idle_cyc[%0d]", j), W'({cyc[j], stb[j]}), '0);
            check($sformatf("idle_rsp[%0d]", j), rsp_vec(j), '0);
        end
    endtask

    // Reset lands after one full BUS cycle of an ibus fetch.
    task automatic reset_mid_bus();
        s_ia = $urandom;
        drive_ibus();
        @(posedge clk); @(negedge clk);
        ibus_stb = 1'b0;
        core_ack = 1'b0;
        for (int j = 0; j < 2; j++)
            check($sformatf("pre_rst_bus[%0d]", j), bus_vec(j), W'({2'b11, 1'b0, 4'hF, s_ia, 32'h0}));
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("rst_bus[%0d]", j), bus_vec(j), '0);
            check($sformatf("rst_rsp[%0d]", j), rsp_vec(j), '0);
        end
        rst = 1'b0;
        lg[0] = 1'b0;
        lg[1] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                check($sformatf("post_rst_bus[%0d] n%0d", j, n), bus_vec(j), '0);
                check($sformatf("post_rst_rsp[%0d] n%0d", j, n), rsp_vec(j), '0);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b1;
        ibus_stb   = 1'b0;
        ibus_addr  = '0;
        dbus_stb   = 1'b0;
        dbus_rw    = 1'b0;
        dbus_addr  = '0;
        dbus_wdata = '0;
        dbus_ben   = '0;
        core_ack   = 1'b0;
        core_rdata = '0;
        lg[0]      = 1'b0;
        lg[1]      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("reset_bus[%0d]", j), bus_vec(j), '0);
            check($sformatf("reset_rsp[%0d]", j), rsp_vec(j), '0);
        end
        rst = 1'b0;

        // simultaneous requests straight after reset, four times
        for (int r = 0; r < 4; r++) begin
            kind = 3;
            randomize_round();
            na[0] = 1'b0;
            na[1] = 1'b0;
            run_round();
        end

        // single fetch, memory acks two cycles after cyc rises
        kind = 1;
        randomize_round();
        s_ia  = 32'h0000_0100;
        lat[0] = 2;
        na[0]  = 1'b0;
        rd[0]  = 32'hDEAD_BEEF;
        run_round();

        // partial-word data write
        kind = 2;
        randomize_round();
        s_rw  = 1'b1;
        s_da  = 32'h8000_0004;
        s_dd  = 32'h1234_5678;
        s_ben = 4'b0011;
        na[0] = 1'b0;
        run_round();

        // fetch that is never acknowledged
        kind = 1;
        randomize_round();
        na[0] = 1'b1;
        run_round();

        reset_mid_bus();
        kind = 1;
        randomize_round();
        na[0] = 1'b0;
        run_round();

        for (int r = 0; r < N_RANDOM; r++) begin
            kind = $urandom_range(1, 5);
            randomize_round();
            run_round();
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover_expected: got %0d entries required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
